ppu_issue_fifo: RTL and testbench

Input issue buffer for the posit processing unit. It accepts operation requests (opcode plus two N-bit posit operands) from the host through a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents them one at a time to the PPU datapath and to `ppu_control_unit` (`issue_valid_o` drives its `valid_i`, `issue_op_o` drives its `op`). It holds the presented request unchanged while the control unit asserts `stall_o`.

---
 rtl/ppu_issue_fifo.sv | 179 +++++++++++++++++
 tb/tb_ppu_issue_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_issue_fifo.sv
// ---------------------------------------------------------------------------
// ppu_issue_fifo
//
// Input issue buffer for the posit processing unit. Host requests (opcode
// plus two N-bit posit operands) arrive over a valid/ready handshake and are
// queued in a DEPTH-entry FIFO. The head is moved into a registered output
// stage that feeds the PPU datapath and ppu_control_unit. The presented
// request is held unchanged while the control unit stalls.
//
// Optional feature macro: PPU_ISSUE_BYPASS_EN
//   When defined, a legal request pushed into an empty FIFO on an unstalled
//   edge is loaded directly into the output register, giving a one-edge
//   push-to-issue latency. When undefined, every request goes through FIFO
//   storage.
//
// Ports
//   clk              : clock, rising edge
//   rst              : synchronous active-high reset
//   in_valid_i       : host request valid
//   in_ready_o       : FIFO can accept (from registered count only)
//   in_op_i          : request opcode (ADD/SUB/MUL/DIV)
//   in_operand1_i    : first posit operand
//   in_operand2_i    : second posit operand
//   stall_i          : stall from ppu_control_unit
//   issue_valid_o    : registered, request presented this cycle
//   issue_op_o       : registered opcode
//   issue_operand1_o : registered first operand
//   issue_operand2_o : registered second operand
//   count_o          : FIFO occupancy, excluding the output register
//   err_o            : sticky, an illegal opcode was received
// ---------------------------------------------------------------------------
module ppu_issue_fifo #(
    parameter int N       = 16,
    parameter int DEPTH   = 4,
    parameter int OP_SIZE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [OP_SIZE-1:0]         in_op_i,
    input  logic [N-1:0]               in_operand1_i,
    input  logic [N-1:0]               in_operand2_i,
    input  logic                       stall_i,
    output logic                       issue_valid_o,
    output logic [OP_SIZE-1:0]         issue_op_o,
    output logic [N-1:0]               issue_operand1_o,
    output logic [N-1:0]               issue_operand2_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = OP_SIZE + 2*N;

    // Shared PPU opcode encoding; every other encoding is illegal.
    localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_MUL = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_DIV = OP_SIZE'(3);

    logic [EW-1:0]      mem_q [DEPTH];
    logic [PW-1:0]      wrPtr_q, wrPtr_d;
    logic [PW-1:0]      rdPtr_q, rdPtr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               valid_q, valid_d;
    logic [OP_SIZE-1:0] op_q, op_d;
    logic [N-1:0]       opnd1_q, opnd1_d;
    logic [N-1:0]       opnd2_q, opnd2_d;
    logic               err_q, err_d;

    logic               pushFire;
    logic               opLegal;
    logic               pushLegal;
    logic               fifoEmpty;
    logic               popFire;
    logic               bypassFire;
    logic               fifoWrite;
    logic [EW-1:0]      headEntry;

    // Ready is a pure function of the registered count, so neither the host
    // valid nor the stall can reach it combinationally.
    assign in_ready_o = (count_q != CW'(DEPTH));

    // Handshake qualification. Illegal opcodes still complete the handshake
    // so the host never deadlocks on a bad request; they are simply dropped.
    always_comb begin
        pushFire  = in_valid_i && in_ready_o;
        opLegal   = (in_op_i == OP_ADD) || (in_op_i == OP_SUB) ||
                    (in_op_i == OP_MUL) || (in_op_i == OP_DIV);
        pushLegal = pushFire && opLegal;
        fifoEmpty = (count_q == '0);
        popFire   = !stall_i && !fifoEmpty;
`ifdef PPU_ISSUE_BYPASS_EN
        bypassFire = pushLegal && fifoEmpty && !stall_i;
`else
        bypassFire = 1'b0;
`endif
        fifoWrite = pushLegal && !bypassFire;
        headEntry = mem_q[rdPtr_q];
    end

    // Next-state for pointers, occupancy, the output stage and the sticky
    // error flag. Full/empty come from the count, never from comparing
    // pointers. The output stage only moves when not stalled; with nothing
    // to issue it drops valid but keeps the last op/operands.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        valid_d = valid_q;
        op_d    = op_q;
        opnd1_d = opnd1_q;
        opnd2_d = opnd2_q;
        err_d   = err_q || (pushFire && !opLegal);
        count_d = count_q + CW'(fifoWrite) - CW'(popFire);

        if (fifoWrite) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end

        if (!stall_i) begin
            if (popFire) begin
                rdPtr_d = rdPtr_q + PW'(1);
                valid_d = 1'b1;
                op_d    = headEntry[EW-1 -: OP_SIZE];
                opnd1_d = headEntry[2*N-1 -: N];
                opnd2_d = headEntry[N-1:0];
            end else if (bypassFire) begin
                valid_d = 1'b1;
                op_d    = in_op_i;
                opnd1_d = in_operand1_i;
                opnd2_d = in_operand2_i;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Control and output registers. Reset discards everything queued or
    // presented by clearing count and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            op_q    <= '0;
            opnd1_q <= '0;
            opnd2_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            opnd1_q <= opnd1_d;
            opnd2_q <= opnd2_d;
            err_q   <= err_d;
        end
    end

    // Entry storage needs no reset: an entry is only ever read after it has
    // been written, as guarded by the count.
    always_ff @(posedge clk) begin
        if (fifoWrite) begin
            mem_q[wrPtr_q] <= {in_op_i, in_operand1_i, in_operand2_i};
        end
    end

    assign issue_valid_o    = valid_q;
    assign issue_op_o       = op_q;
    assign issue_operand1_o = opnd1_q;
    assign issue_operand2_o = opnd2_q;
    assign count_o          = count_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_ppu_issue_fifo.sv
// ---------------------------------------------------------------------------
// tb_ppu_issue_fifo
//
// Self-checking bench for ppu_issue_fifo. Directed stimulus pushes the
// expected issue sequence into a scoreboard queue; a monitor on the falling
// edge pops and compares each newly presented request, and checks that a
// stalled request is held unchanged. Direct checks on count/ready/err/valid
// are made #1 after each rising edge.
// ---------------------------------------------------------------------------
module tb_ppu_issue_fifo;

    localparam int N       = 16;
    localparam int DEPTH   = 4;
    localparam int OP_SIZE = 3;
    localparam int CW      = $clog2(DEPTH+1);

    localparam logic [OP_SIZE-1:0] OP_ADD = 3'd0;
    localparam logic [OP_SIZE-1:0] OP_SUB = 3'd1;
    localparam logic [OP_SIZE-1:0] OP_MUL = 3'd2;
    localparam logic [OP_SIZE-1:0] OP_DIV = 3'd3;
    localparam logic [OP_SIZE-1:0] OP_BAD = 3'd7;

`ifdef PPU_ISSUE_BYPASS_EN
    localparam int STALL_EDGE = 3;
`else
    localparam int STALL_EDGE = 4;
`endif

    typedef struct packed {
        logic [OP_SIZE-1:0] op;
        logic [N-1:0]       a;
        logic [N-1:0]       b;
    } req_t;

    logic               clk;
    logic               rst;
    logic               inValid;
    logic               inReady;
    logic [OP_SIZE-1:0] inOp;
    logic [N-1:0]       inA;
    logic [N-1:0]       inB;
    logic               stall;
    logic               issueValid;
    logic [OP_SIZE-1:0] issueOp;
    logic [N-1:0]       issueA;
    logic [N-1:0]       issueB;
    logic [CW-1:0]      count;
    logic               err;

    int   checks = 0;
    int   errors = 0;
    req_t sb[$];
    req_t lastIssued;
    logic stallSeen;
    logic rstSeen;

    ppu_issue_fifo #(.N(N), .DEPTH(DEPTH), .OP_SIZE(OP_SIZE)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (inValid),
        .in_ready_o       (inReady),
        .in_op_i          (inOp),
        .in_operand1_i    (inA),
        .in_operand2_i    (inB),
        .stall_i          (stall),
        .issue_valid_o    (issueValid),
        .issue_op_o       (issueOp),
        .issue_operand1_o (issueA),
        .issue_operand2_o (issueB),
        .count_o          (count),
        .err_o            (err)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what the DUT saw at each rising edge so the monitor knows
    // whether the output register was allowed to advance.
    always @(posedge clk) begin
        stallSeen = stall;
        rstSeen   = rst;
    end

    // Monitor: a valid output after an unstalled edge is a new issue and must
    // match the scoreboard head; after a stalled edge it must equal the
    // previously presented request.
    always @(negedge clk) begin
        if (!rstSeen && issueValid) begin
            checks++;
            if (!stallSeen) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL issue_unexpected op=%0d a=%h b=%h, required none", issueOp, issueA, issueB);
                end else begin
                    lastIssued = sb.pop_front();
                    if ({issueOp, issueA, issueB} !== lastIssued) begin
                        errors++;
                        $display("[TB] FAIL issue_order got op=%0d a=%h b=%h, required op=%0d a=%h b=%h",
                                 issueOp, issueA, issueB, lastIssued.op, lastIssued.a, lastIssued.b);
                    end
                end
            end else if ({issueOp, issueA, issueB} !== lastIssued) begin
                errors++;
                $display("[TB] FAIL stall_hold got op=%0d a=%h b=%h, required op=%0d a=%h b=%h",
                         issueOp, issueA, issueB, lastIssued.op, lastIssued.a, lastIssued.b);
            end
        end
    end

    // Drive one cycle of inputs, then wait until just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [OP_SIZE-1:0] op,
                                 input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic s);
        inValid = v;
        inOp    = op;
        inA     = a;
        inB     = b;
        stall   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
        rst = 1'b0;
    endtask

    req_t fillReq [5];

    initial begin
        rst     = 1'b1;
        inValid = 1'b0;
        inOp    = OP_ADD;
        inA     = '0;
        inB     = '0;
        stall   = 1'b0;
        lastIssued = '0;

        // Reset then idle
        doReset();
        checkOutput("rst_valid", 32'(issueValid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_ready", 32'(inReady), 32'd1);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_payload", 32'({issueOp, issueA} | 32'(issueB)), 32'd0);

        // Single op
        sb.push_back('{OP_ADD, 16'h4000, 16'h3000});
        applyStimulus(1'b1, OP_ADD, 16'h4000, 16'h3000, 1'b0);
`ifdef PPU_ISSUE_BYPASS_EN
        checkOutput("single_e1_valid", 32'(issueValid), 32'd1);
        checkOutput("single_e1_count", 32'(count), 32'd0);
        checkOutput("single_e1_op1", 32'(issueA), 32'h4000);
        idle(1);
        checkOutput("single_e2_valid", 32'(issueValid), 32'd0);
`else
        checkOutput("single_e1_valid", 32'(issueValid), 32'd0);
        checkOutput("single_e1_count", 32'(count), 32'd1);
        idle(1);
        checkOutput("single_e2_valid", 32'(issueValid), 32'd1);
        checkOutput("single_e2_op1", 32'(issueA), 32'h4000);
        checkOutput("single_e2_op2", 32'(issueB), 32'h3000);
        checkOutput("single_e2_count", 32'(count), 32'd0);
`endif
        idle(1);
        checkOutput("single_e3_valid", 32'(issueValid), 32'd0);
        checkOutput("single_e3_hold_op", 32'(issueOp), 32'(OP_ADD));

        // Fill / full under stall
        fillReq[0] = '{OP_ADD, 16'h1000, 16'h2000};
        fillReq[1] = '{OP_SUB, 16'h1001, 16'h2001};
        fillReq[2] = '{OP_MUL, 16'h1002, 16'h2002};
        fillReq[3] = '{OP_DIV, 16'h1003, 16'h2003};
        fillReq[4] = '{OP_ADD, 16'h1004, 16'h2004};
        for (int i = 0; i < 5; i++) sb.push_back(fillReq[i]);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, fillReq[i].op, fillReq[i].a, fillReq[i].b, 1'b1);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_ready", 32'(inReady), (i < 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, fillReq[4].op, fillReq[4].a, fillReq[4].b, 1'b1);
        checkOutput("full_hold_count", 32'(count), 32'd4);
        checkOutput("full_hold_ready", 32'(inReady), 32'd0);
        checkOutput("full_hold_valid", 32'(issueValid), 32'd0);
        applyStimulus(1'b1, fillReq[4].op, fillReq[4].a, fillReq[4].b, 1'b0);
        checkOutput("full_pop_count", 32'(count), 32'd3);
        checkOutput("full_pop_ready", 32'(inReady), 32'd1);
        applyStimulus(1'b1, fillReq[4].op, fillReq[4].a, fillReq[4].b, 1'b0);
        checkOutput("pushpop_count", 32'(count), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            idle(1);
            checkOutput("drain_count", 32'(count), 32'(i));
        end
        idle(1);
        checkOutput("drain_bubble", 32'(issueValid), 32'd0);

        // Stall hold while ADD is presented
        sb.push_back('{OP_DIV, 16'h5000, 16'h4800});
        sb.push_back('{OP_ADD, 16'h3800, 16'h3c00});
        sb.push_back('{OP_MUL, 16'h4400, 16'h4200});
        for (int e = 1; e <= 6; e++) begin
            case (e)
                1:       applyStimulus(1'b1, OP_DIV, 16'h5000, 16'h4800, e == STALL_EDGE);
                2:       applyStimulus(1'b1, OP_ADD, 16'h3800, 16'h3c00, e == STALL_EDGE);
                3:       applyStimulus(1'b1, OP_MUL, 16'h4400, 16'h4200, e == STALL_EDGE);
                default: applyStimulus(1'b0, OP_ADD, '0, '0, e == STALL_EDGE);
            endcase
            if (e == STALL_EDGE) begin
                checkOutput("stall_valid", 32'(issueValid), 32'd1);
                checkOutput("stall_op", 32'(issueOp), 32'(OP_ADD));
                checkOutput("stall_op1", 32'(issueA), 32'h3800);
            end
            if (e == STALL_EDGE + 1) begin
                checkOutput("after_stall_op", 32'(issueOp), 32'(OP_MUL));
            end
        end
        idle(1);

        // Illegal opcode between two MULs
        sb.push_back('{OP_MUL, 16'h4100, 16'h4100});
        sb.push_back('{OP_MUL, 16'h4300, 16'h4300});
        applyStimulus(1'b1, OP_MUL, 16'h4100, 16'h4100, 1'b0);
        checkOutput("illegal_pre_err", 32'(err), 32'd0);
        applyStimulus(1'b1, OP_BAD, 16'hdead, 16'hbeef, 1'b0);
        checkOutput("illegal_count", 32'(count), 32'd0);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_ready", 32'(inReady), 32'd1);
        applyStimulus(1'b1, OP_MUL, 16'h4300, 16'h4300, 1'b0);
        idle(3);
        checkOutput("illegal_err_sticky", 32'(err), 32'd1);
        doReset();
        checkOutput("illegal_rst_err", 32'(err), 32'd0);

        // Reset mid-stream: four queued, one presented, three left queued
        for (int i = 0; i < 4; i++) begin
            sb.push_back(fillReq[i]);
            applyStimulus(1'b1, fillReq[i].op, fillReq[i].a, fillReq[i].b, 1'b1);
        end
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
        checkOutput("mid_count", 32'(count), 32'd3);
        checkOutput("mid_valid", 32'(issueValid), 32'd1);
        #5;
        sb.delete();
        rst   = 1'b1;
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
        rst   = 1'b0;
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_valid", 32'(issueValid), 32'd0);
        checkOutput("mid_rst_ready", 32'(inReady), 32'd1);
        checkOutput("mid_rst_op", 32'(issueOp), 32'd0);
        idle(6);
        checkOutput("mid_after_valid", 32'(issueValid), 32'd0);

        // Nothing expected may be left unissued.
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
